rob_multi_commit: RTL

//  Parametrised reorder buffer: in-order allocation, out-of-order writeback from
//  WB_PORTS execution channels, in-order commit of up to COMMIT_W entries/cycle.

---
 rtl/rob_multi_commit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rob_multi_commit.sv
// rtl/rob_multi_commit.sv - reorder buffer with multi-port writeback and multi-slot in-order commit
module rob_multi_commit #(
    parameter int DEPTH    = 16,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int WB_PORTS = 4,
    parameter int COMMIT_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [REG_W-1:0]             alloc_rd,
    input  logic [1:0]                   alloc_kind,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_npc,
    input  logic [WB_PORTS-1:0]          wb_taken,
    output logic [COMMIT_W-1:0]          cm_valid,
    output logic [COMMIT_W-1:0]          cm_we,
    output logic [COMMIT_W*REG_W-1:0]    cm_rd,
    output logic [COMMIT_W*DATA_W-1:0]   cm_data,
    output logic [COMMIT_W*TAG_W-1:0]    cm_tag,
    output logic                         redirect_valid,
    output logic [DATA_W-1:0]            redirect_pc,
    output logic [TAG_W-1:0]             head_tag,
    output logic                         head_store,
    output logic [TAG_W:0]               count
);

    localparam logic [1:0] K_ALU    = 2'd0;
    localparam logic [1:0] K_STORE  = 2'd1;
    localparam logic [1:0] K_JUMP   = 2'd2;
    localparam logic [1:0] K_BRANCH = 2'd3;
    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]        valid_q, valid_d, ready_q, ready_d, taken_q, taken_d;
    logic [REG_W-1:0]        rd_q   [DEPTH];
    logic [REG_W-1:0]        rd_d   [DEPTH];
    logic [1:0]              kind_q [DEPTH];
    logic [1:0]              kind_d [DEPTH];
    logic [DATA_W-1:0]       data_q [DEPTH];
    logic [DATA_W-1:0]       data_d [DEPTH];
    logic [DATA_W-1:0]       npc_q  [DEPTH];
    logic [DATA_W-1:0]       npc_d  [DEPTH];
    logic [TAG_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]          count_q, count_d, n_commit;
    logic [COMMIT_W-1:0]     cm_valid_q, cm_valid_d, cm_we_q, cm_we_d;
    logic [COMMIT_W*REG_W-1:0]  cm_rd_q, cm_rd_d;
    logic [COMMIT_W*DATA_W-1:0] cm_data_q, cm_data_d;
    logic [COMMIT_W*TAG_W-1:0]  cm_tag_q, cm_tag_d;
    logic                    redirect_q, redirect_d;
    logic [DATA_W-1:0]       redirect_pc_q, redirect_pc_d;
    logic                    alloc_acc, grp_open;
    logic [TAG_W-1:0]        slot, wtag;

    assign alloc_ready    = (count_q != DEPTH_C);
    assign alloc_tag      = tail_q;
    assign head_tag       = head_q;
    assign head_store     = valid_q[head_q] && (kind_q[head_q] == K_STORE) && !ready_q[head_q];
    assign count          = count_q;
    assign cm_valid       = cm_valid_q;
    assign cm_we          = cm_we_q;
    assign cm_rd          = cm_rd_q;
    assign cm_data        = cm_data_q;
    assign cm_tag         = cm_tag_q;
    assign redirect_valid = redirect_q;
    assign redirect_pc    = redirect_pc_q;

    // Commit group: consecutive ready entries from head; a control transfer closes the group.
    always_comb begin
        cm_valid_d    = '0;
        cm_we_d       = '0;
        cm_rd_d       = '0;
        cm_data_d     = '0;
        cm_tag_d      = '0;
        n_commit      = '0;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        grp_open      = 1'b1;
        slot          = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            slot = head_q + TAG_W'(i);
            if (grp_open && valid_q[slot] && ready_q[slot]) begin
                cm_valid_d[i]                  = 1'b1;
                cm_we_d[i]                     = (kind_q[slot] == K_ALU) || (kind_q[slot] == K_JUMP);
                cm_rd_d[i*REG_W +: REG_W]      = rd_q[slot];
                cm_data_d[i*DATA_W +: DATA_W]  = data_q[slot];
                cm_tag_d[i*TAG_W +: TAG_W]     = slot;
                n_commit                       = n_commit + (TAG_W+1)'(1);
                if ((kind_q[slot] == K_JUMP) || (kind_q[slot] == K_BRANCH)) begin
                    grp_open = 1'b0;
                    if ((kind_q[slot] == K_JUMP) || taken_q[slot]) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = npc_q[slot];
                    end
                end
            end else begin
                grp_open = 1'b0;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        taken_d = taken_q;
        rd_d    = rd_q;
        kind_d  = kind_q;
        data_d  = data_q;
        npc_d   = npc_q;
        wtag    = '0;
        // Ascending port order lets the highest port win on a tag collision.
        for (int p = 0; p < WB_PORTS; p++) begin
            wtag = wb_tag[p*TAG_W +: TAG_W];
            if (wb_valid[p] && valid_q[wtag]) begin
                ready_d[wtag] = 1'b1;
                taken_d[wtag] = wb_taken[p];
                data_d[wtag]  = wb_data[p*DATA_W +: DATA_W];
                npc_d[wtag]   = wb_npc[p*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < COMMIT_W; i++) begin
            if (cm_valid_d[i]) valid_d[cm_tag_d[i*TAG_W +: TAG_W]] = 1'b0;
        end
        alloc_acc = alloc_valid && alloc_ready && !redirect_d;
        head_d    = head_q + n_commit[TAG_W-1:0];
        tail_d    = tail_q;
        count_d   = count_q - n_commit;
        if (alloc_acc) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
            taken_d[tail_q] = 1'b0;
            rd_d[tail_q]    = alloc_rd;
            kind_d[tail_q]  = alloc_kind;
            tail_d          = tail_q + TAG_W'(1);
            count_d         = count_d + (TAG_W+1)'(1);
        end
        if (redirect_d) begin
            valid_d = '0;
            tail_d  = head_d;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            ready_q       <= '0;
            taken_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            cm_valid_q    <= '0;
            cm_we_q       <= '0;
            cm_rd_q       <= '0;
            cm_data_q     <= '0;
            cm_tag_q      <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            valid_q       <= valid_d;
            ready_q       <= ready_d;
            taken_q       <= taken_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            cm_valid_q    <= cm_valid_d;
            cm_we_q       <= cm_we_d;
            cm_rd_q       <= cm_rd_d;
            cm_data_q     <= cm_data_d;
            cm_tag_q      <= cm_tag_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        kind_q <= kind_d;
        data_q <= data_d;
        npc_q  <= npc_d;
    end

endmodule
